alu_exec: RTL and testbench
===========================

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 The block SHALL provide one clock and an asynchronous, active-low reset, named as the codebase names them: clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 operation_code  input  4  ALU operation from ALU control: 0010 ADD, 0110 SUB, 0000 AND, 0001 ORR, 0111 PASSB, 1100 NOR, 1000 MUL.
REQ-006 a  input  64  operand A (Rn).
REQ-007 b  input  64  operand B (Rm / extended immediate).
REQ-008 busy  output  1  high while an operation is in flight.
REQ-009 done  output  1  one-cycle pulse; result, zero and illegal are valid from this cycle on.
REQ-010 result  output  64  registered result.
REQ-011 zero  output  1  registered flag, high when result is all zeros.
REQ-012 illegal  output  1  registered flag, high when the last accepted operation_code was not in REQ-005.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, MUL, DONE.
REQ-014 On start=1 in IDLE, the block SHALL latch a, b and operation_code; the inputs are don't-care afterwards.
REQ-015 For ADD, SUB, AND, ORR, PASSB, NOR and illegal codes, the FSM SHALL go IDLE->DONE; done=1 in the cycle after start (latency 1).
REQ-016 ADD/SUB SHALL be modulo 2^64: a+b and a-b (a + ~b + 1). Carry-out and borrow SHALL be discarded.
REQ-017 AND, ORR and NOR SHALL be bitwise; PASSB SHALL give result=b (used for CBZ).
REQ-018 An illegal code SHALL give result=0, illegal=1 and zero=1. Every legal code SHALL give illegal=0.
REQ-019 For MUL, the FSM SHALL go IDLE->MUL and run a shift-add multiply, one multiplier bit per cycle, for exactly 64 cycles with no early exit.
REQ-020 After 64 MUL cycles, the FSM SHALL go to DONE. done SHALL be asserted 65 cycles after the start cycle.
REQ-021 The MUL result SHALL be the low 64 bits of the unsigned product a*b; upper bits SHALL be discarded.
REQ-022 A 7-bit iteration counter SHALL count 0..63 in MUL and clear on entry to MUL.
REQ-023 busy SHALL be 1 in the cycle after start through the done cycle inclusive, and 0 in IDLE.
REQ-024 DONE SHALL last one cycle and then go to IDLE unconditionally. start in DONE SHALL be ignored, not queued.
REQ-025 start during MUL or DONE SHALL be ignored, with no effect on state or operands.
REQ-026 result, zero and illegal SHALL update only in the done cycle and hold until the next done or reset.
REQ-027 A start in the IDLE cycle right after DONE SHALL be accepted (back-to-back throughput of one op per 2 cycles for single-cycle codes).

Reset
REQ-028 rst_n=0 SHALL immediately, without waiting for clk, force: state=IDLE, busy=0, done=0, result=0, zero=0, illegal=0, counter=0.
REQ-029 Reset during MUL SHALL abort the operation; no done SHALL follow.
REQ-030 After rst_n deasserts, the first start SHALL be accepted on the first rising edge with rst_n=1.

Verification
REQ-031 ADD: a=0xFFFF_FFFF_FFFF_FFFF, b=1, start -> next cycle done=1, result=0, zero=1, busy=1.
REQ-032 SUB then AND back-to-back:
- SUB a=5, b=7 -> result=0xFFFF_FFFF_FFFF_FFFE, zero=0.
- start in the following IDLE cycle with AND a=0xF0, b=0x3C -> result=0x30.
REQ-033 MUL: a=0x1_0000_0001, b=3, start -> done exactly 65 cycles later, result=0x3_0000_0003; busy=1 for 65 cycles; a start pulse mid-MUL has no effect.
REQ-034 MUL overflow: a=2^63, b=2 -> result=0, zero=1, illegal=0.
REQ-035 Illegal: operation_code=1111 -> next cycle done=1, result=0, illegal=1; a following ORR a=1, b=2 -> result=3, illegal=0.
REQ-036 Reset: assert rst_n=0 at MUL cycle 30 -> outputs clear asynchronously and no done appears. After release, PASSB with b=0x1234 -> result=0x1234 one cycle after start.

Source files
------------

// File: rtl/alu_exec.sv
// Multi-cycle 64-bit execute ALU: single-cycle logic/arith ops and a
// 64-iteration shift-add multiplier, sequenced by a three-state FSM.
module alu_exec (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [3:0]  operation_code,
   input  logic [63:0] a,
   input  logic [63:0] b,
   output logic        busy,
   output logic        done,
   output logic [63:0] result,
   output logic        zero,
   output logic        illegal
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_ORR   = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_PASSB = 4'b0111;
   localparam logic [3:0] OP_MUL   = 4'b1000;
   localparam logic [3:0] OP_NOR   = 4'b1100;

   localparam logic [6:0] LAST_ITER = 7'd63;

   logic [1:0]  state;
   logic [63:0] mcand;
   logic [63:0] mplier;
   logic [63:0] acc;
   logic [6:0]  iter;

   logic [63:0] alu_res;
   logic        alu_illegal;
   logic [63:0] acc_next;

   // Single-cycle ops are evaluated straight from the inputs in the
   // accepting cycle, so their operands never need a separate register.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path
      // through the case leaves it unassigned and infers a latch.
      alu_res     = '0;
      alu_illegal = 1'b0;
      case (operation_code)
         OP_ADD:   alu_res = a + b;
         OP_SUB:   alu_res = a + ~b + 64'd1;
         OP_AND:   alu_res = a & b;
         OP_ORR:   alu_res = a | b;
         OP_PASSB: alu_res = b;
         OP_NOR:   alu_res = ~(a | b);
         default:  alu_illegal = 1'b1;
      endcase
   end

   assign acc_next = acc + (mplier[0] ? mcand : 64'd0);

   assign busy = (state != ST_IDLE);
   assign done = (state == ST_DONE);

   // NOTE: state is updated with non-blocking assignments only, so every
   // register samples its inputs from before the clock edge.
   // NOTE: the multiplier datapath is reset as well, keeping X out of
   // simulation even though its contents are reloaded on every MUL entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         mcand   <= '0;
         mplier  <= '0;
         acc     <= '0;
         iter    <= '0;
         result  <= '0;
         zero    <= 1'b0;
         illegal <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (operation_code == OP_MUL) begin
                     state  <= ST_MUL;
                     mcand  <= a;
                     mplier <= b;
                     acc    <= '0;
                     iter   <= '0;
                  end else begin
                     state   <= ST_DONE;
                     result  <= alu_res;
                     zero    <= (alu_res == 64'd0);
                     illegal <= alu_illegal;
                  end
               end
            end
            ST_MUL: begin
               // One multiplier bit per cycle; the final partial sum is
               // committed directly so DONE follows the 64th iteration.
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               if (iter == LAST_ITER) begin
                  state   <= ST_DONE;
                  result  <= acc_next;
                  zero    <= (acc_next == 64'd0);
                  illegal <= 1'b0;
               end else begin
                  iter <= iter + 7'd1;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: directed cases plus random ops, expected
// values from a plain-arithmetic model, checked by an independent monitor.
module tb_alu_exec;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  operation_code = '0;
   logic [63:0] a = '0;
   logic [63:0] b = '0;
   logic        busy;
   logic        done;
   logic [63:0] result;
   logic        zero;
   logic        illegal;

   alu_exec dut (
      .clk(clk), .rst_n(rst_n), .start(start), .operation_code(operation_code),
      .a(a), .b(b), .busy(busy), .done(done), .result(result), .zero(zero),
      .illegal(illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] r;
      logic        z;
      logic        ill;
      int          lat;
      int          issue;
   } exp_t;

   exp_t sb[$];
   int n_checks = 0;
   int n_fail = 0;
   int cycle = 0;
   logic [63:0] last_r = '0;
   logic        last_z = 1'b0;
   logic        last_i = 1'b0;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: the architectural meaning of each code.
   function automatic exp_t model(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y);
      exp_t e;
      e.ill = 1'b0;
      e.lat = 1;
      e.issue = 0;
      case (op)
         4'b0010: e.r = x + y;
         4'b0110: e.r = x - y;
         4'b0000: e.r = x & y;
         4'b0001: e.r = x | y;
         4'b0111: e.r = y;
         4'b1100: e.r = ~(x | y);
         4'b1000: begin e.r = x * y; e.lat = 65; end
         default: begin e.r = '0; e.ill = 1'b1; end
      endcase
      e.z = (e.r == 64'd0);
      return e;
   endfunction

   // Monitor: pops on done, otherwise checks that outputs hold.
   always @(negedge clk) begin
      if (rst_n) begin
         if (done) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 64'(done), 64'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("result", result, e.r);
               check("zero", 64'(zero), 64'(e.z));
               check("illegal", 64'(illegal), 64'(e.ill));
               check("latency", 64'(cycle - e.issue), 64'(e.lat));
               check("busy_on_done", 64'(busy), 64'd1);
               last_r = e.r;
               last_z = e.z;
               last_i = e.ill;
            end
         end else begin
            check("result_hold", result, last_r);
            check("flags_hold", {62'd0, zero, illegal}, {62'd0, last_z, last_i});
         end
      end
   end

   // Present one op at a negedge so the next rising edge accepts it.
   task automatic issue(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y);
      exp_t e;
      start = 1'b1;
      operation_code = op;
      a = x;
      b = y;
      e = model(op, x, y);
      e.issue = cycle;
      sb.push_back(e);
   endtask

   // Wait until the DUT is idle; optionally hammer it with ignored starts
   // and changing operands while it is busy.
   task automatic wait_idle(input bit junk);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         start = junk;
         operation_code = 4'($urandom);
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         if (n == 1) check("busy_after_start", 64'(busy), 64'd1);
      end while (busy && n < 200);
      start = 1'b0;
      if (busy) check("idle_timeout", 64'(busy), 64'd0);
   endtask

   task automatic run(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y, input bit junk);
      issue(op, x, y);
      wait_idle(junk);
   endtask

   logic [3:0] codes [7] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1100, 4'b1000};

   initial begin
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_outs", {result[63:2], result[1:0] | {zero, illegal}}, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
      run(4'b0110, 64'd5, 64'd7, 1'b0);
      run(4'b0000, 64'hF0, 64'h3C, 1'b0);
      run(4'b1000, 64'h1_0000_0001, 64'd3, 1'b1);
      run(4'b1000, 64'h8000_0000_0000_0000, 64'd2, 1'b0);
      run(4'b1111, 64'd9, 64'd9, 1'b0);
      run(4'b0001, 64'd1, 64'd2, 1'b0);
      run(4'b1100, 64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF, 1'b1);

      for (int i = 0; i < 40; i++) begin
         logic [3:0] op;
         int sel;
         sel = $urandom_range(0, 9);
         op = (sel < 7) ? codes[sel] : 4'($urandom);
         run(op, {$urandom, $urandom}, {$urandom, $urandom}, i[0]);
      end

      // Abort a multiply at iteration 30 with an asynchronous reset.
      issue(4'b1000, 64'hDEAD_BEEF_1234_5678, 64'h0BAD_F00D_0000_0007);
      repeat (31) begin
         @(negedge clk);
         start = 1'b0;
      end
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_result", result, 64'd0);
      check("abort_flags", {62'd0, zero, illegal}, 64'd0);
      sb.delete();
      last_r = '0;
      last_z = 1'b0;
      last_i = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run(4'b0111, 64'd77, 64'h1234, 1'b0);
      repeat (70) @(negedge clk);

      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
